chrow_loader: RTL and testbench
===============================

// Module: chrow_loader
// PURPOSE
//   Per-scanline sequencer for the character renderer. Once per line, during horizontal blanking, it
//   decides whether the character row buffer needs new data. If so, it copies one text row of
//   attribute/code words from text memory into chrowbuf, then pulses render_go with the pixel row.
//   Sits between timing_gen (line_start) and the chrowbuf write port / renderer start.
// PARAMETERS
//   COLS       100  text cells per row (800 px / 8); chrowbuf words written per load
//   CHAR_H_LG2 4    log2 of character height in pixel rows (16)
//   TEXT_AW    12   text memory address width; base address wraps mod 2^TEXT_AW
// PORTS
//   clk              in   1        40 MHz pixel clock
//   nrst             in   1        reset: synchronous, active-low
//   line_start       in   1        1-cycle pulse at start of horizontal blanking
//   next_row         in   16       display pixel row to be rendered next (valid with line_start)
//   next_row_vis     in   1        1 = next_row is a visible row (valid with line_start)
//   text_rd          out  1        text memory read strobe, active-low
//   text_rd_addr     out  TEXT_AW  text memory read address
//   text_rd_data     in   16       read data, valid the cycle after text_rd=0
//   chrowbuf_wr      out  1        chrowbuf write strobe, active-low
//   chrowbuf_wr_addr out  8        chrowbuf write address (0..COLS-1)
//   chrowbuf_wr_data out  16       chrowbuf write data {bg[3:0],fg[3:0],code[7:0]}
//   render_go        out  1        1-cycle pulse: chrowbuf is ready, renderer may start
//   render_pix_row   out  CHAR_H_LG2  pixel row within character cell; held until next render_go
//   busy             out  1        1 while state != IDLE
//   overrun          out  1        sticky: line_start arrived while busy
// BEHAVIOUR
//   Reset (nrst=0 at posedge): state=IDLE, text_rd=1, chrowbuf_wr=1, render_go=0, busy=0,
//     overrun=0, render_pix_row=0, base=0, addresses=0. Applies mid-LOAD: all strobes inactive next cycle.
//   States: IDLE -> LOAD -> GO -> IDLE, or IDLE -> GO -> IDLE.
//   IDLE: on line_start & next_row_vis:
//     pix = next_row[CHAR_H_LG2-1:0]
//     If next_row==0: base<=0.
//     If pix==0: go to LOAD.
//     Else: go to GO.
//     line_start & !next_row_vis: stay IDLE, no outputs.
//   LOAD, read pipeline:
//     Cycle k (k=0..COLS-1): text_rd=0, text_rd_addr=base+k.
//     Cycle k+1: chrowbuf_wr=0, chrowbuf_wr_addr=k, chrowbuf_wr_data=text_rd_data.
//     Exactly COLS writes occur in sequence, with no gaps.
//     Last write is in cycle COLS.
//     Next cycle: base<=base+COLS (wraps mod 2^TEXT_AW), go to GO.
//     LOAD lasts COLS+1 cycles (101 of the 256 blanking cycles).
//   GO: render_go=1 for one cycle, render_pix_row<=pix, then IDLE.
//   Latency line_start -> render_go:
//     pix!=0: 1 cycle.
//     pix==0: COLS+2 cycles.
//   Overrun: line_start while busy=1 is ignored (no state change) and sets overrun=1.
//     overrun stays set until reset.
//   Base tracking: base is not multiplied. It reloads to 0 at next_row==0 and advances by COLS once per
//     completed load. A reset mid-LOAD discards the advance.
//   text_rd and chrowbuf_wr are 1 in every cycle not listed above; write addresses never exceed COLS-1.
// TESTING
//   1. Pulse line_start with next_row=0, vis=1; text mem[i]=i:
//      - 100 writes, addr 0..99, data 0..99, starting one cycle after the first text_rd.
//      - render_go at +102, pix_row=0.
//   2. Then pulse with next_row=1..15:
//      - No chrowbuf writes.
//      - render_go 1 cycle later each time; pix_row=1..15.
//   3. Pulse with next_row=16:
//      - Reads addr 100..199, writes 0..99.
//      - Then next_row=0 again: reads restart at addr 0.
//   4. Pulse line_start again 50 cycles into a LOAD:
//      - overrun=1.
//      - The load completes unchanged, with one render_go.
//      - overrun stays 1 until nrst=0.
//   5. Pulse with vis=0, next_row=600: no strobes, no render_go, busy stays 0.
//   6. Assert nrst=0 at write #40, then release:
//      - Strobes are 1 the next cycle, busy=0.
//      - The next next_row=16 load reads from base 0.
//   7. Run 37 loads with TEXT_AW=12: base sequence 0,100,...,3600; the 42nd load wraps mod 4096.

Source files
------------

// File: rtl/chrow_loader_if.sv
// Bundle of the scanline sequencer's handshake and bus signals.
//   master: the loader side (drives the read/write strobes, render start, status flags)
//   slave : the environment side (timing_gen pulse, text memory data, chrowbuf, renderer)
interface chrow_loader_if #(
  parameter int unsigned TEXT_AW    = 12,
  parameter int unsigned CHAR_H_LG2 = 4
);
  logic                  line_start;
  logic [15:0]           next_row;
  logic                  next_row_vis;
  logic                  text_rd;
  logic [TEXT_AW-1:0]    text_rd_addr;
  logic [15:0]           text_rd_data;
  logic                  chrowbuf_wr;
  logic [7:0]            chrowbuf_wr_addr;
  logic [15:0]           chrowbuf_wr_data;
  logic                  render_go;
  logic [CHAR_H_LG2-1:0] render_pix_row;
  logic                  busy;
  logic                  overrun;

  modport master (
    input  line_start, next_row, next_row_vis, text_rd_data,
    output text_rd, text_rd_addr, chrowbuf_wr, chrowbuf_wr_addr, chrowbuf_wr_data,
           render_go, render_pix_row, busy, overrun
  );

  modport slave (
    output line_start, next_row, next_row_vis, text_rd_data,
    input  text_rd, text_rd_addr, chrowbuf_wr, chrowbuf_wr_addr, chrowbuf_wr_data,
           render_go, render_pix_row, busy, overrun
  );
endinterface

// File: rtl/chrow_loader.sv
// Per-scanline sequencer for the character renderer. On each visible line_start it either
// copies one text row (COLS words) from text memory into chrowbuf and then starts the
// renderer, or (mid-character rows) starts the renderer immediately.
// Ports:
//   clk, nrst          : pixel clock, synchronous active-low reset
//   bus (master)       : line_start/next_row/next_row_vis in; text memory read port;
//                        chrowbuf write port; render_go/render_pix_row; busy/overrun status
module chrow_loader #(
  parameter int unsigned COLS       = 100,
  parameter int unsigned CHAR_H_LG2 = 4,
  parameter int unsigned TEXT_AW    = 12
) (
  input  logic           clk,
  input  logic           nrst,
  chrow_loader_if.master bus
);

  localparam int unsigned CNT_W = $clog2(COLS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, GO} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TEXT_AW-1:0]    base_q, base_d;
  logic [TEXT_AW-1:0]    addr_q, addr_d;
  logic [CHAR_H_LG2-1:0] pix_q, pix_d;
  logic [CHAR_H_LG2-1:0] pix_row_q, pix_row_d;
  logic                  text_rd_q, text_rd_d;
  logic                  wr_q, wr_d;
  logic [7:0]            wr_addr_q, wr_addr_d;
  logic                  go_q, go_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    addr_d    = addr_q;
    pix_d     = pix_q;
    pix_row_d = pix_row_q;
    text_rd_d = 1'b1;
    wr_d      = 1'b1;
    wr_addr_d = wr_addr_q;
    go_d      = 1'b0;
    // Any line_start outside IDLE is dropped but remembered.
    overrun_d = overrun_q | (bus.line_start & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (bus.line_start && bus.next_row_vis) begin
          pix_d = bus.next_row[CHAR_H_LG2-1:0];
          if (bus.next_row == 16'd0) base_d = '0;
          if (pix_d == '0) begin
            state_d   = LOAD;
            cnt_d     = '0;
            text_rd_d = 1'b0;
            addr_d    = base_d;
          end else begin
            state_d   = GO;
            go_d      = 1'b1;
            pix_row_d = pix_d;
          end
        end
      end
      // cnt_q = k: read k is on the bus now, its write lands next cycle.
      LOAD: begin
        if (cnt_q == CNT_W'(COLS)) begin
          state_d   = GO;
          base_d    = base_q + TEXT_AW'(COLS);
          go_d      = 1'b1;
          pix_row_d = pix_q;
        end else begin
          wr_d      = 1'b0;
          wr_addr_d = 8'(cnt_q);
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q != CNT_W'(COLS - 1)) begin
            text_rd_d = 1'b0;
            addr_d    = base_q + TEXT_AW'(cnt_q) + TEXT_AW'(1);
          end
        end
      end
      GO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      pix_q     <= '0;
      pix_row_q <= '0;
      text_rd_q <= 1'b1;
      wr_q      <= 1'b1;
      wr_addr_q <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      pix_q     <= pix_d;
      pix_row_q <= pix_row_d;
      text_rd_q <= text_rd_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.text_rd          = text_rd_q;
  assign bus.text_rd_addr     = addr_q;
  assign bus.chrowbuf_wr      = wr_q;
  assign bus.chrowbuf_wr_addr = wr_addr_q;
  // Memory data arrives in the same cycle as its write strobe, so it passes straight through.
  assign bus.chrowbuf_wr_data = bus.text_rd_data;
  assign bus.render_go        = go_q;
  assign bus.render_pix_row   = pix_row_q;
  assign bus.busy             = busy_q;
  assign bus.overrun          = overrun_q;

endmodule

// File: tb/tb_chrow_loader.sv
// Bench for chrow_loader: event-schedule model of reads, writes, render starts and status,
// compared every cycle, plus hand-computed expectations per scenario.
module tb_chrow_loader;
  localparam int COLS = 100;
  localparam int AW   = 12;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  chrow_loader_if #(.TEXT_AW(AW), .CHAR_H_LG2(4)) bus ();

  chrow_loader #(.COLS(COLS), .CHAR_H_LG2(4), .TEXT_AW(AW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #12 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Text memory: synchronous read, data valid the cycle after the strobe.
  logic [15:0] mem [4096];
  always @(posedge clk) if (bus.text_rd == 1'b0) bus.text_rd_data <= mem[bus.text_rd_addr];

  // Model: expected events keyed by cycle number.
  int rd_ev[int];
  int wr_addr_ev[int];
  int wr_data_ev[int];
  int go_ev[int];
  int busy_ev[int];
  int ovr_ev[int];
  int rst_ev[int];
  int m_base = 0;
  int m_pix = 0;
  bit m_ovr = 1'b0;
  int pc = 0;

  // Observed activity.
  int wr_cnt = 0, rd_cnt = 0, go_cnt = 0;
  int last_go_cyc = -1, first_rd_addr = -1, first_rd_cyc = -1, first_wr_cyc = -1;
  int last_wr_data = -1;
  logic prev_rd = 1'b1, prev_wr = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = cyc;
      if (rst_ev.exists(n)) begin m_ovr = 1'b0; m_pix = 0; end
      if (ovr_ev.exists(n)) m_ovr = 1'b1;
      if (go_ev.exists(n)) m_pix = go_ev[n];
      check("text_rd", 32'(bus.text_rd), 32'(!rd_ev.exists(n)));
      if (rd_ev.exists(n)) check("text_rd_addr", 32'(bus.text_rd_addr), 32'(rd_ev[n]));
      check("chrowbuf_wr", 32'(bus.chrowbuf_wr), 32'(!wr_addr_ev.exists(n)));
      if (wr_addr_ev.exists(n)) begin
        check("wr_addr", 32'(bus.chrowbuf_wr_addr), 32'(wr_addr_ev[n]));
        check("wr_data", 32'(bus.chrowbuf_wr_data), 32'(wr_data_ev[n]));
      end
      check("render_go", 32'(bus.render_go), 32'(go_ev.exists(n)));
      check("pix_row", 32'(bus.render_pix_row), 32'(m_pix));
      check("busy", 32'(bus.busy), 32'(busy_ev.exists(n)));
      check("overrun", 32'(bus.overrun), 32'(m_ovr));
      if (bus.chrowbuf_wr == 1'b0) begin
        wr_cnt++;
        last_wr_data = int'(bus.chrowbuf_wr_data);
        if (prev_wr) first_wr_cyc = n;
      end
      if (bus.text_rd == 1'b0) begin
        rd_cnt++;
        if (prev_rd) begin first_rd_addr = int'(bus.text_rd_addr); first_rd_cyc = n; end
      end
      if (bus.render_go) begin go_cnt++; last_go_cyc = n; end
      prev_wr = bus.chrowbuf_wr;
      prev_rd = bus.text_rd;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle line_start; the model schedules what the DUT must do from the next cycle on.
  task automatic pulse(input int row, input bit vis);
    int pix, a;
    @(posedge clk); #1;
    pc = cyc;
    bus.line_start = 1'b1;
    bus.next_row = 16'(row);
    bus.next_row_vis = vis;
    if (busy_ev.exists(pc)) begin
      ovr_ev[pc + 1] = 1;
    end else if (vis) begin
      pix = row % 16;
      if (row == 0) m_base = 0;
      if (pix == 0) begin
        for (int k = 0; k < COLS; k++) begin
          a = (m_base + k) % 4096;
          rd_ev[pc + 1 + k] = a;
          wr_addr_ev[pc + 2 + k] = k;
          wr_data_ev[pc + 2 + k] = int'(mem[a]);
        end
        for (int c = pc + 1; c <= pc + COLS + 2; c++) busy_ev[c] = 1;
        go_ev[pc + COLS + 2] = 0;
        m_base = (m_base + COLS) % 4096;
      end else begin
        go_ev[pc + 1] = pix;
        busy_ev[pc + 1] = 1;
      end
    end
    @(posedge clk); #1;
    bus.line_start = 1'b0;
  endtask

  // One-cycle reset pulse; everything scheduled after it is cancelled.
  task automatic do_reset();
    int r;
    @(posedge clk); #1;
    r = cyc;
    nrst = 1'b0;
    for (int c = r + 1; c <= r + 300; c++) begin
      rd_ev.delete(c); wr_addr_ev.delete(c); wr_data_ev.delete(c);
      go_ev.delete(c); busy_ev.delete(c); ovr_ev.delete(c);
    end
    rst_ev[r + 1] = 1;
    m_base = 0;
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  initial begin
    int w0, r0, g0, c0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    bus.line_start = 1'b0;
    bus.next_row = 16'd0;
    bus.next_row_vis = 1'b0;
    bus.text_rd_data = 16'd0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    chk_en = 1'b1;
    check("rst_text_rd", 32'(bus.text_rd), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Row 0: full load from base 0.
    w0 = wr_cnt;
    pulse(0, 1'b1); c0 = pc;
    idle(103);
    check("t1_writes", 32'(wr_cnt - w0), 32'd100);
    check("t1_first_rd", 32'(first_rd_addr), 32'd0);
    check("t1_wr_after_rd", 32'(first_wr_cyc - first_rd_cyc), 32'd1);
    check("t1_last_data", 32'(last_wr_data), 32'd99);
    check("t1_go_lat", 32'(last_go_cyc - c0), 32'd102);
    check("t1_pix", 32'(bus.render_pix_row), 32'd0);

    // Rows 1..15: no load, immediate start.
    for (int r = 1; r < 16; r++) begin
      w0 = wr_cnt;
      pulse(r, 1'b1); c0 = pc;
      idle(2);
      check("t2_go_lat", 32'(last_go_cyc - c0), 32'd1);
      check("t2_pix", 32'(bus.render_pix_row), 32'(r));
      check("t2_no_wr", 32'(wr_cnt - w0), 32'd0);
    end

    // Row 16 continues at base 100; row 0 restarts at 0.
    pulse(16, 1'b1); idle(103);
    check("t3_base100", 32'(first_rd_addr), 32'd100);
    pulse(0, 1'b1); idle(103);
    check("t3_base0", 32'(first_rd_addr), 32'd0);

    // Overrun: second line_start 50 cycles into a load.
    g0 = go_cnt; w0 = wr_cnt;
    pulse(16, 1'b1); c0 = pc;
    idle(48);
    pulse(32, 1'b1);
    check("t4_pulse_at50", 32'(pc - c0), 32'd50);
    idle(60);
    check("t4_overrun", 32'(bus.overrun), 32'd1);
    check("t4_one_go", 32'(go_cnt - g0), 32'd1);
    check("t4_writes", 32'(wr_cnt - w0), 32'd100);
    idle(20);
    check("t4_sticky", 32'(bus.overrun), 32'd1);

    // Invisible row: nothing happens.
    w0 = wr_cnt; r0 = rd_cnt; g0 = go_cnt;
    pulse(600, 1'b0); idle(5);
    check("t5_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("t5_no_rd", 32'(rd_cnt - r0), 32'd0);
    check("t5_no_go", 32'(go_cnt - g0), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);

    // Reset during the 40th write of a load.
    w0 = wr_cnt;
    pulse(16, 1'b1);
    idle(39);
    do_reset();
    check("t6_writes", 32'(wr_cnt - w0), 32'd40);
    check("t6_rd_idle", 32'(bus.text_rd), 32'd1);
    check("t6_wr_idle", 32'(bus.chrowbuf_wr), 32'd1);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_ovr_clr", 32'(bus.overrun), 32'd0);
    idle(2);
    pulse(16, 1'b1); idle(103);
    check("t6_base0", 32'(first_rd_addr), 32'd0);

    // 42 consecutive loads starting at row 0: base walks by 100 and wraps at 4096.
    for (int j = 0; j < 42; j++) begin
      pulse(16 * j, 1'b1); idle(103);
      check("t7_base", 32'(first_rd_addr), 32'((j * 100) % 4096));
      if (j == 36) check("t7_base_3600", 32'(first_rd_addr), 32'd3600);
    end
    check("t7_wrap_4", 32'(first_rd_addr), 32'd4);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
